// File: rtl/urp_pcie_fc_scheduler.sv
// ---------------------------------------------------------------------------
// urp_pcie_fc_scheduler
// Credit-aware TLP scheduler. It picks one of the Posted (0), Non-Posted (1)
// and Completion (2) header queues per cycle for the single TX link path.
// A class may be picked only when its header and data flow-control credits
// cover the TLP. Classes that may be picked are served round-robin.
// Credits are consumed on grant and replenished by UpdateFC returns.
// There is a single registered output stage, so one TLP per cycle is possible.
//
// Ports (per-class buses are packed, class c at [c*W +: W]):
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_init_i        pulse: load credit limits and enable scheduling
//   cfg_hcred_i       initial header credits per class (0 = infinite)
//   cfg_dcred_i       initial data credits per class (0 = infinite)
//   src_valid_i       per-class TLP pending
//   src_ready_o       per-class accept this cycle (one-hot or zero)
//   src_data_i        per-class TLP header
//   src_dcred_i       per-class data credits the TLP needs
//   ret_valid_i       per-class credit return strobe
//   ret_hcred_i       per-class header credits returned
//   ret_dcred_i       per-class data credits returned
//   dst_valid_o       output TLP valid
//   dst_ready_i       link side accepts
//   dst_data_o        granted TLP header
//   dst_class_o       class id of dst_data_o
//   cred_blocked_o    registered: valid but credits insufficient
// ---------------------------------------------------------------------------
module urp_pcie_fc_scheduler #(
    parameter int N_CLASS   = 3,
    parameter int DATA_SIZE = 224,
    parameter int HCRED_W   = 8,
    parameter int DCRED_W   = 12
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_init_i,
    input  logic [N_CLASS*HCRED_W-1:0]     cfg_hcred_i,
    input  logic [N_CLASS*DCRED_W-1:0]     cfg_dcred_i,
    input  logic [N_CLASS-1:0]             src_valid_i,
    output logic [N_CLASS-1:0]             src_ready_o,
    input  logic [N_CLASS*DATA_SIZE-1:0]   src_data_i,
    input  logic [N_CLASS*DCRED_W-1:0]     src_dcred_i,
    input  logic [N_CLASS-1:0]             ret_valid_i,
    input  logic [N_CLASS*HCRED_W-1:0]     ret_hcred_i,
    input  logic [N_CLASS*DCRED_W-1:0]     ret_dcred_i,
    output logic                           dst_valid_o,
    input  logic                           dst_ready_i,
    output logic [DATA_SIZE-1:0]           dst_data_o,
    output logic [1:0]                     dst_class_o,
    output logic [N_CLASS-1:0]             cred_blocked_o
);

    typedef enum logic {UNINIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [HCRED_W-1:0]     hcred_q [N_CLASS];
    logic [HCRED_W-1:0]     hcred_d [N_CLASS];
    logic [DCRED_W-1:0]     dcred_q [N_CLASS];
    logic [DCRED_W-1:0]     dcred_d [N_CLASS];
    logic [N_CLASS-1:0]     inf_h_q, inf_h_d, inf_d_q, inf_d_d;
    logic [1:0]             rr_q, rr_d;
    logic                   dst_valid_q, dst_valid_d;
    logic [DATA_SIZE-1:0]   dst_data_q, dst_data_d;
    logic [1:0]             dst_class_q, dst_class_d;
    logic [N_CLASS-1:0]     blk_q, blk_d;

    logic                   run;
    logic                   slot_free;
    logic [N_CLASS-1:0]     elig;
    logic [N_CLASS-1:0]     grant;
    logic                   gnt_any;
    logic [1:0]             gnt_idx;

    // Returns are added first and clipped at all-ones, then the grant cost
    // is removed; the cost never exceeds the pre-return value because
    // eligibility was checked against it.
    function automatic logic [HCRED_W-1:0] upd_h(input logic [HCRED_W-1:0] cur,
                                                 input logic add_en,
                                                 input logic [HCRED_W-1:0] add,
                                                 input logic take);
        logic [HCRED_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : '0);
        if (sum[HCRED_W]) sum = {1'b0, {HCRED_W{1'b1}}};
        if (take) sum = sum - (HCRED_W+1)'(1);
        return sum[HCRED_W-1:0];
    endfunction

    function automatic logic [DCRED_W-1:0] upd_d(input logic [DCRED_W-1:0] cur,
                                                 input logic add_en,
                                                 input logic [DCRED_W-1:0] add,
                                                 input logic [DCRED_W-1:0] cost);
        logic [DCRED_W:0] sum;
        sum = {1'b0, cur} + (add_en ? {1'b0, add} : '0);
        if (sum[DCRED_W]) sum = {1'b0, {DCRED_W{1'b1}}};
        sum = sum - {1'b0, cost};
        return sum[DCRED_W-1:0];
    endfunction

    assign run       = (state_q == RUN);
    assign slot_free = !dst_valid_q || dst_ready_i;

    always_comb begin
        state_d = state_q;
        if (cfg_init_i) state_d = RUN;
    end

    always_comb begin
        elig = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            elig[c] = run && src_valid_i[c]
                   && (inf_h_q[c] || (hcred_q[c] != '0))
                   && (inf_d_q[c] || (dcred_q[c] >= src_dcred_i[c*DCRED_W +: DCRED_W]));
        end
    end

    // Round-robin search starting at rr_q; a credit-blocked class is simply
    // skipped so it cannot stall the others, and rr_q only moves on a grant.
    always_comb begin
        logic [2:0] idx;
        idx     = '0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (slot_free && !cfg_init_i) begin
            for (int k = 0; k < N_CLASS; k++) begin
                idx = {1'b0, rr_q} + 3'(k);
                if (idx >= 3'(N_CLASS)) idx = idx - 3'(N_CLASS);
                if (!gnt_any && elig[idx[1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx[1:0];
                end
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    always_comb begin
        for (int c = 0; c < N_CLASS; c++) begin
            hcred_d[c] = hcred_q[c];
            dcred_d[c] = dcred_q[c];
        end
        inf_h_d = inf_h_q;
        inf_d_d = inf_d_q;
        for (int c = 0; c < N_CLASS; c++) begin
            if (cfg_init_i) begin
                hcred_d[c] = cfg_hcred_i[c*HCRED_W +: HCRED_W];
                dcred_d[c] = cfg_dcred_i[c*DCRED_W +: DCRED_W];
                inf_h_d[c] = (cfg_hcred_i[c*HCRED_W +: HCRED_W] == '0);
                inf_d_d[c] = (cfg_dcred_i[c*DCRED_W +: DCRED_W] == '0);
            end else begin
                // Infinite counters stay frozen: no decrement and no returns.
                if (!inf_h_q[c])
                    hcred_d[c] = upd_h(hcred_q[c], ret_valid_i[c],
                                       ret_hcred_i[c*HCRED_W +: HCRED_W], grant[c]);
                if (!inf_d_q[c])
                    dcred_d[c] = upd_d(dcred_q[c], ret_valid_i[c],
                                       ret_dcred_i[c*DCRED_W +: DCRED_W],
                                       grant[c] ? src_dcred_i[c*DCRED_W +: DCRED_W] : '0);
            end
        end
    end

    always_comb begin
        dst_valid_d = dst_valid_q;
        dst_data_d  = dst_data_q;
        dst_class_d = dst_class_q;
        rr_d        = rr_q;
        // During a cfg_init_i cycle the output register is left untouched.
        if (!cfg_init_i && slot_free) begin
            dst_valid_d = gnt_any;
            if (gnt_any) begin
                dst_data_d  = src_data_i[int'(gnt_idx)*DATA_SIZE +: DATA_SIZE];
                dst_class_d = gnt_idx;
                rr_d        = (gnt_idx == 2'(N_CLASS-1)) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
        blk_d = src_valid_i & ~elig & {N_CLASS{run}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNINIT;
            for (int c = 0; c < N_CLASS; c++) begin
                hcred_q[c] <= '0;
                dcred_q[c] <= '0;
            end
            inf_h_q     <= '0;
            inf_d_q     <= '0;
            rr_q        <= '0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
            dst_class_q <= '0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            for (int c = 0; c < N_CLASS; c++) begin
                hcred_q[c] <= hcred_d[c];
                dcred_q[c] <= dcred_d[c];
            end
            inf_h_q     <= inf_h_d;
            inf_d_q     <= inf_d_d;
            rr_q        <= rr_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
            dst_class_q <= dst_class_d;
            blk_q       <= blk_d;
        end
    end

    assign src_ready_o    = grant;
    assign dst_valid_o    = dst_valid_q;
    assign dst_data_o     = dst_data_q;
    assign dst_class_o    = dst_class_q;
    assign cred_blocked_o = blk_q;

endmodule

// File: tb/tb_urp_pcie_fc_scheduler.sv
// ---------------------------------------------------------------------------
// tb_urp_pcie_fc_scheduler
// Bench for the credit-aware TLP scheduler. A cycle-level reference model
// with integer credit counts and a round-robin pointer predicts grants, the
// output register and the blocked flags. Directed scenarios and a random run
// follow; each scenario compares DUT outputs against the model and its own
// scenario-specific expectations.
// ---------------------------------------------------------------------------
module tb_urp_pcie_fc_scheduler;

    localparam int N  = 3;
    localparam int DS = 224;
    localparam int HW = 8;
    localparam int DW = 12;

    logic clk, rst_n, cfg_init, dst_ready;
    logic [N-1:0]  src_valid, ret_valid;
    logic [HW-1:0] cfg_h [N];
    logic [DW-1:0] cfg_d [N];
    logic [DS-1:0] sdata [N];
    logic [DW-1:0] sdc   [N];
    logic [HW-1:0] rh    [N];
    logic [DW-1:0] rdc   [N];

    logic [N-1:0]  src_ready_o, cred_blocked_o;
    logic          dst_valid_o;
    logic [DS-1:0] dst_data_o;
    logic [1:0]    dst_class_o;

    urp_pcie_fc_scheduler #(.N_CLASS(N), .DATA_SIZE(DS), .HCRED_W(HW), .DCRED_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_init_i     (cfg_init),
        .cfg_hcred_i    ({cfg_h[2], cfg_h[1], cfg_h[0]}),
        .cfg_dcred_i    ({cfg_d[2], cfg_d[1], cfg_d[0]}),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready_o),
        .src_data_i     ({sdata[2], sdata[1], sdata[0]}),
        .src_dcred_i    ({sdc[2], sdc[1], sdc[0]}),
        .ret_valid_i    (ret_valid),
        .ret_hcred_i    ({rh[2], rh[1], rh[0]}),
        .ret_dcred_i    ({rdc[2], rdc[1], rdc[0]}),
        .dst_valid_o    (dst_valid_o),
        .dst_ready_i    (dst_ready),
        .dst_data_o     (dst_data_o),
        .dst_class_o    (dst_class_o),
        .cred_blocked_o (cred_blocked_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int       m_h [N];
    int       m_d [N];
    bit       m_inf_h [N];
    bit       m_inf_d [N];
    int       m_rr;
    bit       m_run;
    bit       m_dv;
    logic [DS-1:0] m_data;
    logic [1:0]    m_cls;
    logic [N-1:0]  m_blk;
    int       gcnt [N];
    logic [N-1:0]  obs_rdy, exp_rdy;

    function automatic logic [DS-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_h[c] = 0; m_d[c] = 0; m_inf_h[c] = 0; m_inf_d[c] = 0; gcnt[c] = 0;
        end
        m_rr = 0; m_run = 0; m_dv = 0; m_data = '0; m_cls = '0; m_blk = '0;
    endtask

    task automatic clear_inputs();
        cfg_init = 0; dst_ready = 1; src_valid = '0; ret_valid = '0;
        for (int c = 0; c < N; c++) begin
            cfg_h[c] = '0; cfg_d[c] = '0; sdata[c] = rnd_data();
            sdc[c] = '0; rh[c] = '0; rdc[c] = '0;
        end
    endtask

    // One clock: sample the combinational accept, step the model across the
    // edge, then return 1 time unit after the edge with registered outputs
    // settled. Accepted sources present a fresh header.
    task automatic cycle();
        logic [N-1:0] elig, g;
        bit slot;
        int idx;
        @(negedge clk);
        obs_rdy = src_ready_o;
        elig = '0; g = '0;
        for (int c = 0; c < N; c++)
            elig[c] = m_run && src_valid[c] && (m_inf_h[c] || m_h[c] >= 1)
                      && (m_inf_d[c] || m_d[c] >= int'(sdc[c]));
        slot = !m_dv || dst_ready;
        if (slot && !cfg_init)
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g == '0 && elig[idx]) g[idx] = 1'b1;
            end
        exp_rdy = g;
        for (int c = 0; c < N; c++) m_blk[c] = src_valid[c] && !elig[c] && m_run;
        if (cfg_init) begin
            for (int c = 0; c < N; c++) begin
                m_h[c] = int'(cfg_h[c]); m_d[c] = int'(cfg_d[c]);
                m_inf_h[c] = (cfg_h[c] == 0); m_inf_d[c] = (cfg_d[c] == 0);
            end
            m_run = 1;
        end else begin
            for (int c = 0; c < N; c++) begin
                if (!m_inf_h[c]) begin
                    m_h[c] = m_h[c] + (ret_valid[c] ? int'(rh[c]) : 0);
                    if (m_h[c] > 255) m_h[c] = 255;
                    if (g[c]) m_h[c] = m_h[c] - 1;
                end
                if (!m_inf_d[c]) begin
                    m_d[c] = m_d[c] + (ret_valid[c] ? int'(rdc[c]) : 0);
                    if (m_d[c] > 4095) m_d[c] = 4095;
                    if (g[c]) m_d[c] = m_d[c] - int'(sdc[c]);
                end
            end
            if (slot) begin
                m_dv = (g != '0);
                for (int c = 0; c < N; c++)
                    if (g[c]) begin
                        m_data = sdata[c]; m_cls = 2'(c); m_rr = (c + 1) % N; gcnt[c]++;
                    end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) if (obs_rdy[c]) sdata[c] = rnd_data();
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        #2;
        checks++;
        if ({dst_valid_o, src_ready_o, cred_blocked_o, dst_class_o} !== '0 || dst_data_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b rdy=%b blk=%b cls=%0d data=%h expected all zero",
                     dst_valid_o, src_ready_o, cred_blocked_o, dst_class_o, dst_data_o);
        end
        @(posedge clk);
        #1 rst_n = 1;
        src_valid = 3'b111;
        for (int c = 0; c < N; c++) sdc[c] = 12'd1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== 3'b000 || dst_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL uninit_no_grant cyc=%0d got rdy=%b v=%b expected rdy=000 v=0",
                         i, obs_rdy, dst_valid_o);
            end
            checks++;
            if (cred_blocked_o !== m_blk) begin
                errors++;
                $display("FAIL uninit_blocked got %b expected %b", cred_blocked_o, m_blk);
            end
        end
    endtask

    task automatic test_round_robin();
        int ngr;
        do_reset();
        for (int c = 0; c < N; c++) begin cfg_h[c] = 8'd4; cfg_d[c] = 12'd16; sdc[c] = 12'd1; end
        src_valid = 3'b111;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        ngr = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== exp_rdy || dst_valid_o !== m_dv) begin
                errors++;
                $display("FAIL rr_model cyc=%0d got rdy=%b v=%b expected rdy=%b v=%b",
                         i, obs_rdy, dst_valid_o, exp_rdy, m_dv);
            end
            if (obs_rdy != '0) begin
                checks++;
                if (obs_rdy !== (3'b001 << (ngr % 3))) begin
                    errors++;
                    $display("FAIL rr_order grant#%0d got %b expected %b", ngr, obs_rdy, 3'b001 << (ngr % 3));
                end
                ngr++;
            end
            if (m_dv) begin
                checks++;
                if (dst_data_o !== m_data || dst_class_o !== m_cls) begin
                    errors++;
                    $display("FAIL rr_data got cls=%0d data=%h expected cls=%0d data=%h",
                             dst_class_o, dst_data_o, m_cls, m_data);
                end
            end
        end
        checks++;
        if (ngr !== 12) begin
            errors++;
            $display("FAIL rr_total_grants got %0d expected 12", ngr);
        end
        checks++;
        if (cred_blocked_o !== 3'b111) begin
            errors++;
            $display("FAIL rr_all_blocked got %b expected 111", cred_blocked_o);
        end
    endtask

    task automatic test_credit_block();
        int g0;
        do_reset();
        cfg_h[0] = 8'd2; cfg_d[0] = 12'd8;
        cfg_h[1] = 8'd0; cfg_d[1] = 12'd0;
        cfg_h[2] = 8'd5; cfg_d[2] = 12'd5;
        sdc[0] = 12'd6; sdc[1] = 12'd5;
        src_valid = 3'b011;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== exp_rdy || cred_blocked_o !== m_blk) begin
                errors++;
                $display("FAIL blk_model cyc=%0d got rdy=%b blk=%b expected rdy=%b blk=%b",
                         i, obs_rdy, cred_blocked_o, exp_rdy, m_blk);
            end
            checks++;
            if (i > 0 && obs_rdy !== 3'b010) begin
                errors++;
                $display("FAIL blk_infinite_class cyc=%0d got %b expected 010", i, obs_rdy);
            end
        end
        g0 = gcnt[0];
        checks++;
        if (g0 !== 1 || cred_blocked_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL blk_class0_once got grants=%0d blk0=%b expected grants=1 blk0=1",
                     g0, cred_blocked_o[0]);
        end
        ret_valid[0] = 1; rdc[0] = 12'd4;
        cycle();
        checks++;
        if (obs_rdy !== 3'b010) begin
            errors++;
            $display("FAIL blk_return_cycle got %b expected 010", obs_rdy);
        end
        ret_valid[0] = 0; rdc[0] = '0;
        cycle();
        checks++;
        if (obs_rdy !== 3'b001) begin
            errors++;
            $display("FAIL blk_after_return got %b expected 001", obs_rdy);
        end
    endtask

    task automatic test_backpressure();
        logic [DS-1:0] cap_data;
        logic [1:0]    cap_cls;
        do_reset();
        for (int c = 0; c < N; c++) begin cfg_h[c] = 8'd50; cfg_d[c] = 12'd200; sdc[c] = 12'(c + 1); end
        src_valid = 3'b111;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        repeat (3) cycle();
        dst_ready = 0;
        cap_data = dst_data_o;
        cap_cls  = dst_class_o;
        checks++;
        if (dst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_before got %b expected 1", dst_valid_o);
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== 3'b000 || dst_valid_o !== 1'b1 || dst_data_o !== cap_data || dst_class_o !== cap_cls) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b cls=%0d expected rdy=000 v=1 cls=%0d data held",
                         i, obs_rdy, dst_valid_o, dst_class_o, cap_cls);
            end
        end
        dst_ready = 1;
        cycle();
        checks++;
        if (obs_rdy !== (3'b001 << ((int'(cap_cls) + 1) % 3))) begin
            errors++;
            $display("FAIL bp_release_order got %b expected %b", obs_rdy, 3'b001 << ((int'(cap_cls) + 1) % 3));
        end
        // extra grants reveal any credit spent while stalled
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== exp_rdy || dst_data_o !== m_data || dst_class_o !== m_cls) begin
                errors++;
                $display("FAIL bp_after got rdy=%b cls=%0d expected rdy=%b cls=%0d",
                         obs_rdy, dst_class_o, exp_rdy, m_cls);
            end
        end
    endtask

    task automatic test_saturation();
        int g0, g1;
        do_reset();
        cfg_h[0] = 8'd1;   cfg_d[0] = 12'd2;
        cfg_h[1] = 8'd250; cfg_d[1] = 12'd0;
        cfg_h[2] = 8'd5;   cfg_d[2] = 12'd5;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        src_valid = 3'b001; sdc[0] = 12'd2;
        ret_valid = 3'b011; rh[0] = 8'd3; rdc[0] = 12'd3; rh[1] = 8'd10;
        cycle();
        checks++;
        if (obs_rdy !== 3'b001) begin
            errors++;
            $display("FAIL sat_same_cycle_grant got %b expected 001", obs_rdy);
        end
        ret_valid = '0; rh[0] = '0; rdc[0] = '0; rh[1] = '0;
        sdc[0] = 12'd1; sdc[1] = 12'd0; src_valid = 3'b011;
        g0 = gcnt[0]; g1 = gcnt[1];
        for (int i = 0; i < 12; i++) begin
            cycle();
            checks++;
            if (obs_rdy !== exp_rdy || cred_blocked_o !== m_blk) begin
                errors++;
                $display("FAIL sat_model cyc=%0d got rdy=%b blk=%b expected rdy=%b blk=%b",
                         i, obs_rdy, cred_blocked_o, exp_rdy, m_blk);
            end
        end
        checks++;
        if (gcnt[0] - g0 !== 3 || gcnt[1] - g1 !== 9) begin
            errors++;
            $display("FAIL sat_grant_counts got c0=%0d c1=%0d expected c0=3 c1=9",
                     gcnt[0] - g0, gcnt[1] - g1);
        end
        checks++;
        if (cred_blocked_o[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL sat_blocked got %b expected 01", cred_blocked_o[1:0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int c = 0; c < N; c++) begin cfg_h[c] = 8'd10; cfg_d[c] = 12'd100; sdc[c] = 12'd1; end
        src_valid = 3'b111;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        repeat (3) cycle();
        checks++;
        if (dst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_valid_before got %b expected 1", dst_valid_o);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (dst_valid_o !== 1'b0 || src_ready_o !== 3'b000) begin
            errors++;
            $display("FAIL mid_async_reset got v=%b rdy=%b expected v=0 rdy=000", dst_valid_o, src_ready_o);
        end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        clear_inputs();
        cfg_h[1] = 8'd3; cfg_d[1] = 12'd3; cfg_h[2] = 8'd3; cfg_d[2] = 12'd3;
        cfg_init = 1;
        cycle();
        cfg_init = 0;
        src_valid = 3'b001;
        for (int i = 0; i < 30; i++) begin
            sdc[0] = 12'($urandom_range(0, 4000));
            ret_valid[0] = 1'($urandom);
            rh[0] = 8'($urandom); rdc[0] = 12'($urandom);
            cycle();
            checks++;
            if (obs_rdy !== 3'b001 || obs_rdy !== exp_rdy) begin
                errors++;
                $display("FAIL mid_infinite cyc=%0d got %b expected 001", i, obs_rdy);
            end
        end
        checks++;
        if (dst_valid_o !== 1'b1 || dst_class_o !== 2'd0 || dst_data_o !== m_data) begin
            errors++;
            $display("FAIL mid_infinite_out got v=%b cls=%0d expected v=1 cls=0", dst_valid_o, dst_class_o);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) pend[c] = src_valid[c] && !obs_rdy[c];
            cfg_init = (i == 0) || ($urandom_range(0, 99) == 0);
            for (int c = 0; c < N; c++) begin
                cfg_h[c] = 8'($urandom_range(0, 5));
                cfg_d[c] = 12'($urandom_range(0, 40));
                if (!pend[c]) begin
                    src_valid[c] = ($urandom_range(0, 3) != 0);
                    sdc[c] = 12'($urandom_range(0, 7));
                    sdata[c] = rnd_data();
                end
                ret_valid[c] = ($urandom_range(0, 3) == 0);
                rh[c] = 8'($urandom_range(0, 2));
                rdc[c] = 12'($urandom_range(0, 9));
            end
            dst_ready = ($urandom_range(0, 3) != 0);
            cycle();
            checks++;
            if (obs_rdy !== exp_rdy || dst_valid_o !== m_dv || cred_blocked_o !== m_blk) begin
                errors++;
                $display("FAIL rand cyc=%0d got rdy=%b v=%b blk=%b expected rdy=%b v=%b blk=%b",
                         i, obs_rdy, dst_valid_o, cred_blocked_o, exp_rdy, m_dv, m_blk);
            end
            if (m_dv) begin
                checks++;
                if (dst_data_o !== m_data || dst_class_o !== m_cls) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got cls=%0d expected cls=%0d", i, dst_class_o, m_cls);
                end
            end
        end
    endtask

    initial begin
        obs_rdy = '0;
        exp_rdy = '0;
        test_reset();
        test_round_robin();
        test_credit_block();
        test_backpressure();
        test_saturation();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
